// File: rtl/aes_pkg.sv
// Shared AES definitions: word/block types, S-box, round constants and the
// controller state encoding used by the key schedule.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  localparam int AES128_ROUNDS = 10;

  typedef enum logic {
    IDLE,
    EXPAND
  } ks_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Forward S-box lookup, also used by the cipher's SubBytes stage.
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Round constant for expansion round r; zero outside 1..10.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_key_schedule_ctrl_if.sv
// Key-load handshake, status and round-key read port of the key schedule.
interface aes_key_schedule_ctrl_if;
  import aes_pkg::*;

  aes_block_t key_in;
  logic       key_valid;
  logic       key_ready;
  logic       clear;
  logic       busy;
  logic       keys_valid;
  logic [3:0] round_cnt;
  logic [3:0] rd_addr;
  aes_block_t rd_data;
  logic       rd_hit;

  // Key loader / cipher datapath side.
  modport master (
    output key_in, key_valid, clear, rd_addr,
    input  key_ready, busy, keys_valid, round_cnt, rd_data, rd_hit
  );

  // Key schedule side.
  modport slave (
    input  key_in, key_valid, clear, rd_addr,
    output key_ready, busy, keys_valid, round_cnt, rd_data, rd_hit
  );
endinterface

// File: rtl/aes_key_round.sv
// One AES-128 key expansion step: derives the next round key from the
// previous one and the round constant. Purely combinational.
module aes_key_round
  import aes_pkg::*;
(
  input  aes_block_t prev_key,
  input  logic [7:0] rcon_in,
  output aes_block_t next_key
);

  aes_word_t w0, w1, w2, w3;
  aes_word_t rot_w, sub_w, t;
  aes_word_t n0, n1, n2, n3;

  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
      assign sub_w[gi*8 +: 8] = sub_byte(rot_w[gi*8 +: 8]);
    end
  endgenerate

  assign t  = sub_w ^ {rcon_in, 24'h0};
  // Each new word chains off the previously produced one.
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key schedule controller: accepts a cipher key, expands one round
// per clock into a key file and serves round keys through a registered port.
module aes_key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input logic                    clk,
  input logic                    reset,
  aes_key_schedule_ctrl_if.slave bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  ks_state_t  state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       keys_valid_q, keys_valid_d;
  logic [3:0] last_wr_q, last_wr_d;
  logic       last_wr_vld_q, last_wr_vld_d;   // low means no slot written yet
  aes_block_t cur_key_q, cur_key_d;           // most recently written key
  aes_block_t rd_data_q, rd_data_d;
  logic       rd_hit_q, rd_hit_d;

  logic       wr_en;
  logic [3:0] wr_addr;
  aes_block_t wr_data;
  aes_block_t next_key;

  aes_block_t key_file [NUM_ROUNDS+1];

  aes_key_round u_round (
    .prev_key (cur_key_q),
    .rcon_in  (rcon(round_q)),
    .next_key (next_key)
  );

  // Next-state, counter and key-file write control; clear overrides all.
  always_comb begin
    state_d       = state_q;
    round_d       = round_q;
    keys_valid_d  = keys_valid_q;
    last_wr_d     = last_wr_q;
    last_wr_vld_d = last_wr_vld_q;
    cur_key_d     = cur_key_q;
    wr_en         = 1'b0;
    wr_addr       = round_q;
    wr_data       = next_key;
    if (bus.clear) begin
      state_d       = IDLE;
      round_d       = 4'd0;
      keys_valid_d  = 1'b0;
      last_wr_vld_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.key_valid) begin
            wr_en         = 1'b1;
            wr_addr       = 4'd0;
            wr_data       = bus.key_in;
            cur_key_d     = bus.key_in;
            round_d       = 4'd1;
            keys_valid_d  = 1'b0;
            last_wr_d     = 4'd0;
            last_wr_vld_d = 1'b1;
            state_d       = EXPAND;
          end
        end
        EXPAND: begin
          wr_en         = 1'b1;
          cur_key_d     = next_key;
          last_wr_d     = round_q;
          last_wr_vld_d = 1'b1;
          if (round_q == LAST_ROUND) begin
            state_d      = IDLE;
            round_d      = 4'd0;
            keys_valid_d = 1'b1;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      round_q       <= 4'd0;
      keys_valid_q  <= 1'b0;
      last_wr_q     <= 4'd0;
      last_wr_vld_q <= 1'b0;
      cur_key_q     <= '0;
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      keys_valid_q  <= keys_valid_d;
      last_wr_q     <= last_wr_d;
      last_wr_vld_q <= last_wr_vld_d;
      cur_key_q     <= cur_key_d;
    end
  end

  // Key file storage; contents are only trusted through rd_hit.
  always_ff @(posedge clk) begin
    if (wr_en) key_file[wr_addr] <= wr_data;
  end

  // Read port: out-of-range addresses return zero; hits see only past writes.
  always_comb begin
    rd_data_d = '0;
    rd_hit_d  = 1'b0;
    if (bus.rd_addr <= LAST_ROUND) begin
      rd_data_d = key_file[bus.rd_addr];
      rd_hit_d  = last_wr_vld_q && (bus.rd_addr <= last_wr_q);
    end
  end

  // Registered read outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
      rd_hit_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_hit_q  <= rd_hit_d;
    end
  end

  assign bus.busy       = (state_q == EXPAND);
  assign bus.key_ready  = (state_q != EXPAND);
  assign bus.keys_valid = keys_valid_q;
  assign bus.round_cnt  = round_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_hit     = rd_hit_q;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Self-checking bench for aes_key_schedule_ctrl: FIPS-197 vectors, random keys
// against a word-level key expansion model, and multi-cycle corner cases.
module tb_aes_key_schedule_ctrl;

  localparam int NR = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] sbox_m [256];
  logic [7:0] rcon_m [11];

  aes_key_schedule_ctrl_if bus ();

  aes_key_schedule_ctrl #(.NUM_ROUNDS(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   addr;
    logic [127:0] exp_data;
    logic         exp_hit;
  } vec_t;

  // ---------------- reference model (GF(2^8) math, FIPS word schedule) ------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  function automatic void build_tables();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rcon_m[0] = 8'h00;
    rcon_m[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rcon_m[i] = xtime(rcon_m[i-1]);
  endfunction

  // Round key idx of cipher key k; zero for indices outside the key file.
  function automatic logic [127:0] model_rk(input logic [127:0] k, input int idx);
    logic [31:0] w [44];
    logic [31:0] tmp;
    if (idx > NR) return 128'h0;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp = tmp ^ {rcon_m[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  // ---------------- helpers ------------------------------------------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    bus.key_in    = k;
    bus.key_valid = 1'b1;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_keys(input string name);
    int n;
    n = 0;
    while (bus.keys_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({name, " latency"}, 128'(n), 128'(NR));
  endtask

  task automatic read_slot(input int a, output logic [127:0] d, output logic h);
    bus.rd_addr = 4'(a);
    tick();
    d = bus.rd_data;
    h = bus.rd_hit;
  endtask

  task automatic check_read(input string name, input int a, input logic [127:0] exp_d, input logic exp_h);
    logic [127:0] d;
    logic         h;
    read_slot(a, d, h);
    check({name, " data"}, d, exp_d);
    check({name, " hit"}, 128'(h), 128'(exp_h));
  endtask

  // ---------------- stimulus -----------------------------------------------
  initial begin
    vec_t         vecs [6];
    logic [127:0] ka, kb, k;
    logic [127:0] fips, zero;

    build_tables();
    fips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    zero = 128'h0;

    reset         = 1'b1;
    bus.key_in    = '0;
    bus.key_valid = 1'b0;
    bus.clear     = 1'b0;
    bus.rd_addr   = 4'd0;

    #12;
    check("reset busy",       128'(bus.busy),       128'd0);
    check("reset key_ready",  128'(bus.key_ready),  128'd1);
    check("reset keys_valid", 128'(bus.keys_valid), 128'd0);
    check("reset round_cnt",  128'(bus.round_cnt),  128'd0);
    check("reset rd_data",    bus.rd_data,          128'd0);
    check("reset rd_hit",     128'(bus.rd_hit),     128'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Known-answer table.
    vecs[0] = '{fips, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b1};
    vecs[1] = '{fips, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1};
    vecs[2] = '{fips, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1};
    vecs[3] = '{zero, 4'd1,  128'h62636363626363636263636362636363, 1'b1};
    vecs[4] = '{zero, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b1};
    vecs[5] = '{fips, 4'd12, 128'h0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      load_key(vecs[i].key);
      wait_keys($sformatf("vec%0d", i));
      check_read($sformatf("vec%0d addr%0d", i, vecs[i].addr), int'(vecs[i].addr),
                 vecs[i].exp_data, vecs[i].exp_hit);
      $display("vector %0d key=%h addr=%0d read=%h hit=%0d", i, vecs[i].key,
               vecs[i].addr, bus.rd_data, bus.rd_hit);
    end

    // Random keys against the model, every address.
    for (int i = 0; i < 30; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load_key(k);
      wait_keys($sformatf("rnd%0d", i));
      for (int a = 0; a < 16; a++)
        check_read($sformatf("rnd%0d addr%0d", i, a), a, model_rk(k, a), (a <= NR));
      $display("random key %0d %h expanded", i, k);
    end

    // Reads during expansion, key_valid held high throughout.
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    bus.key_in    = ka;
    bus.key_valid = 1'b1;
    tick();
    check("exp round_cnt start", 128'(bus.round_cnt), 128'd1);
    check("exp key_ready low",   128'(bus.key_ready), 128'd0);
    tick();
    tick();
    check("exp round_cnt 3", 128'(bus.round_cnt), 128'd3);
    bus.key_in = kb;
    begin
      logic [127:0] d;
      logic         h;
      int           n;
      read_slot(5, d, h);
      check("exp slot5 not yet hit", 128'(h), 128'd0);
      read_slot(2, d, h);
      check("exp slot2 hit",  128'(h), 128'd1);
      check("exp slot2 data", d, model_rk(ka, 2));
      n = 0;
      while (bus.keys_valid !== 1'b1 && n < 40) begin
        check("exp key_ready held low", 128'(bus.key_ready), 128'd0);
        tick();
        n++;
      end
      bus.key_valid = 1'b0;
      check("exp remaining latency", 128'(n), 128'(NR - 4));
      check("exp key_ready back", 128'(bus.key_ready), 128'd1);
    end
    check_read("exp no reload slot0",  0,  ka, 1'b1);
    check_read("exp no reload slot10", 10, model_rk(ka, 10), 1'b1);
    $display("expansion-read sequence key=%h", ka);

    // clear at round 4, then clear racing a key_valid, then reload.
    k = {$urandom, $urandom, $urandom, $urandom};
    load_key(k);
    tick();
    tick();
    tick();
    check("clr round_cnt 4", 128'(bus.round_cnt), 128'd4);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    check("clr busy",       128'(bus.busy),       128'd0);
    check("clr keys_valid", 128'(bus.keys_valid), 128'd0);
    check("clr round_cnt",  128'(bus.round_cnt),  128'd0);
    check("clr key_ready",  128'(bus.key_ready),  128'd1);
    for (int a = 0; a < 16; a++) begin
      logic [127:0] d;
      logic         h;
      read_slot(a, d, h);
      check($sformatf("clr addr%0d hit", a), 128'(h), 128'd0);
    end
    bus.clear     = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_in    = k;
    tick();
    bus.clear     = 1'b0;
    bus.key_valid = 1'b0;
    check("clr blocks load", 128'(bus.busy), 128'd0);
    load_key(k);
    wait_keys("clr reload");
    check_read("clr reload slot10", 10, model_rk(k, 10), 1'b1);
    check_read("clr reload slot4",  4,  model_rk(k, 4),  1'b1);
    $display("clear sequence key=%h", k);

    // Asynchronous reset between edges mid-expansion.
    k = {$urandom, $urandom, $urandom, $urandom};
    bus.rd_addr = 4'd10;
    load_key(k);
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    check("arst busy",       128'(bus.busy),       128'd0);
    check("arst key_ready",  128'(bus.key_ready),  128'd1);
    check("arst keys_valid", 128'(bus.keys_valid), 128'd0);
    check("arst round_cnt",  128'(bus.round_cnt),  128'd0);
    check("arst rd_data",    bus.rd_data,          128'd0);
    check("arst rd_hit",     128'(bus.rd_hit),     128'd0);
    #1;
    reset = 1'b0;
    check_read("arst slot0 stale", 0, k, 1'b0);
    for (int a = 11; a < 16; a++)
      check_read($sformatf("arst addr%0d", a), a, 128'h0, 1'b0);
    $display("async reset sequence key=%h", k);

    // Back-to-back: load B in the cycle keys_valid rises for A.
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    load_key(ka);
    wait_keys("b2b A");
    load_key(kb);
    check("b2b keys_valid drop", 128'(bus.keys_valid), 128'd0);
    check("b2b busy",            128'(bus.busy),       128'd1);
    wait_keys("b2b B");
    check_read("b2b slot0",  0,  kb, 1'b1);
    check_read("b2b slot7",  7,  model_rk(kb, 7),  1'b1);
    check_read("b2b slot10", 10, model_rk(kb, 10), 1'b1);
    $display("back-to-back A=%h B=%h", ka, kb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule_ctrl.md
Name: aes_key_schedule_ctrl

Overview:
Sequences AES-128 key expansion and holds the full round-key set for the cipher round datapath. It accepts a 128-bit cipher key over a valid/ready handshake and iterates one expansion round per clock, driving the round number 1..NUM_ROUNDS. Each resulting round key is stored in an internal key file, which the cipher datapath reads through a registered random-access port. It sits between key-load logic and the encryption round pipeline.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds; legal range 1..10, limited by the Rcon table; key-file depth = NUM_ROUNDS+1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
key_in  input  128  cipher key; byte 0 = bits[127:120]; word w0 = bits[127:96] (FIPS-197 order).
key_valid  input  1  key_in is valid.
key_ready  output  1  block can accept a key; equals !busy.
clear  input  1  synchronous: abort expansion, invalidate keys.
busy  output  1  expansion in progress.
keys_valid  output  1  all NUM_ROUNDS+1 keys are stored and stable.
round_cnt  output  4  current expansion round (0 when idle).
rd_addr  input  4  key-file index, 0..NUM_ROUNDS.
rd_data  output  128  registered read data, 1-cycle latency.
rd_hit  output  1  registered: the addressed slot held a valid key at read time.

Behaviour:
- Reset (async) values: state=IDLE, busy=0, key_ready=1, keys_valid=0, round_cnt=0, rd_data=0, rd_hit=0, last_wr=none. Key-file contents need no reset; rd_hit gates their use.
- States: IDLE, EXPAND.
- IDLE: a load occurs when key_valid && key_ready. On the load edge: slot[0]<=key_in; round_cnt<=1; keys_valid<=0; last_wr<=0; go to EXPAND.
- EXPAND, each cycle with round_cnt=r:
  - slot[r] <= expand(slot[r-1], rcon(r)); last_wr <= r.
  - If r==NUM_ROUNDS: go to IDLE, round_cnt<=0, keys_valid<=1.
  - Otherwise round_cnt<=r+1.
- expand(): t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'. All arithmetic is XOR; no carries.
- rcon(r): 01,02,04,08,10,20,40,80,1b,36 for r=1..10; 00 otherwise.
- Latency: with the load handshake at edge 0, slot r is written at edge r and keys_valid rises at edge NUM_ROUNDS (10 by default). key_ready returns high in the same cycle keys_valid rises.
- key_ready=0 during EXPAND; key_valid is ignored there. There is no queuing.
- A new load while keys_valid=1 is legal: keys_valid drops on the load edge and the old key set is lost.
- clear: highest priority after reset. It forces IDLE, round_cnt=0, keys_valid=0, last_wr=none. A key_valid asserted in the same cycle as clear is not accepted.
- Read port:
  - rd_data <= slot[rd_addr] every cycle.
  - rd_hit <= (rd_addr <= last_wr).
  - rd_addr > NUM_ROUNDS gives rd_data=0 and rd_hit=0.
  - Reads during EXPAND are legal. A slot is hit only after its write edge; a read of slot r issued in the same cycle slot r is written returns rd_hit=0 (no write-to-read bypass).
- Reset asserted mid-expansion: immediate return to the reset values. The key file holds stale data, masked by rd_hit=0.

Decomposition:
- Shared package aes_pkg holds:
  - the S-box function sub_byte (shared with the cipher's SubBytes);
  - the rcon function;
  - the typedefs aes_word_t (32 bits) and aes_block_t (128 bits);
  - the constant AES128_ROUNDS = 10.
- One combinational sub-module, aes_key_round: input prev key (128) and rcon (8); output next key (128). It contains 4 sub_byte instances. The controller owns the FSM, counter, key file and read port.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c: load, wait for keys_valid (edge 10). Required: rd_addr=1 -> a0fafe1788542cb123a339392a6c7605; rd_addr=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; both with rd_hit=1.
- All-zero key: slot 1 = 62636363626363636263636362636363; slot 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- During expansion: rd_addr=5 at round_cnt=3 -> rd_hit=0; rd_addr=2 -> rd_hit=1 with the correct key. key_valid held high during EXPAND -> no second load; key_ready stays 0 until done.
- clear at round_cnt=4 -> next cycle busy=0, keys_valid=0, rd_hit=0 for all addresses. Reload -> correct keys at 10 edges.
- Async reset asserted mid-EXPAND, between clock edges -> outputs go to reset values immediately. rd_addr=11..15 -> rd_data=0, rd_hit=0.
- Back-to-back: load key A; at keys_valid load key B the same cycle -> keys_valid drops, B's keys are valid 10 edges later, and slot 0 reads B.
